// File: rtl/mod_arbiter.sv
// mod_arbiter: round-robin share of one constant-modulus divider across NUM_REQ requesters.
// Optional quotient output enabled by defining MOD_ARB_QUOTIENT_EN.
`default_nettype none

module mod_comb #(
  parameter int          DIVIDER         = 12,
  parameter logic [33:0] ONE_DIV_DIVIDER = 34'h2AAAAAAAA
) (
  input  logic [15:0] dividend,
`ifdef MOD_ARB_QUOTIENT_EN
  output logic [15:0] quotient,
`endif
  output logic [15:0] result
);
  localparam int          SHIFT = 37;
  localparam logic [15:0] DIV16 = 16'(DIVIDER);

  logic [15:0] q_est;
  logic [15:0] rem_est;
  logic        fix;

  // The reciprocal may be truncated, so the estimate can be one low; a single
  // correction step makes both quotient and remainder exact over 0..65535.
  always_comb begin
    q_est   = 16'(({34'd0, dividend} * {16'd0, ONE_DIV_DIVIDER}) >> SHIFT);
    rem_est = dividend - q_est * DIV16;
    fix     = (rem_est >= DIV16);
    result  = fix ? (rem_est - DIV16) : rem_est;
  end

`ifdef MOD_ARB_QUOTIENT_EN
  assign quotient = fix ? (q_est + 16'd1) : q_est;
`endif
endmodule

module mod_arbiter #(
  parameter int          NUM_REQ         = 4,
  parameter int          ID_W            = $clog2(NUM_REQ),
  parameter int          DIVIDER         = 12,
  parameter logic [33:0] ONE_DIV_DIVIDER = 34'h2AAAAAAAA
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [16*NUM_REQ-1:0] i_req_dividend,
  output logic [NUM_REQ-1:0]    o_req_ready,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [ID_W-1:0]       o_rsp_id,
`ifdef MOD_ARB_QUOTIENT_EN
  output logic [15:0]           o_rsp_quotient,
`endif
  output logic [15:0]           o_rsp_result
);
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    next_ptr;
  logic               any_valid;
  logic [NUM_REQ-1:0] grant;
  logic               s1_v;
  logic [ID_W-1:0]    s1_id;
  logic [15:0]        s1_div;
  logic               s2_adv;
  logic               s1_free;
  logic               accept;
  logic [15:0]        res_c;
  int                 idx;

  assign s2_adv  = !o_rsp_valid || i_rsp_ready;
  assign s1_free = !s1_v || s2_adv;

  // Walk from the farthest offset down to rr_ptr so the closest valid
  // requester is the last (winning) assignment.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (i_req_valid[idx]) begin
        winner    = ID_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (any_valid) grant[winner] = 1'b1;
  end

  assign o_req_ready = grant & {NUM_REQ{s1_free & i_rst_n}};
  assign accept      = |o_req_ready;
  assign next_ptr    = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

`ifdef MOD_ARB_QUOTIENT_EN
  logic [15:0] quo_c;
`endif

  mod_comb #(
    .DIVIDER         (DIVIDER),
    .ONE_DIV_DIVIDER (ONE_DIV_DIVIDER)
  ) u_mod (
    .dividend (s1_div),
`ifdef MOD_ARB_QUOTIENT_EN
    .quotient (quo_c),
`endif
    .result   (res_c)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_v         <= 1'b0;
      s1_id        <= '0;
      s1_div       <= '0;
      rr_ptr       <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_id     <= '0;
      o_rsp_result <= '0;
`ifdef MOD_ARB_QUOTIENT_EN
      o_rsp_quotient <= '0;
`endif
    end else begin
      if (accept) begin
        s1_v   <= 1'b1;
        s1_id  <= winner;
        s1_div <= i_req_dividend[int'(winner)*16 +: 16];
        rr_ptr <= next_ptr;
      end else if (s1_free) begin
        s1_v <= 1'b0;
      end

      if (s2_adv && s1_v) begin
        o_rsp_valid  <= 1'b1;
        o_rsp_id     <= s1_id;
        o_rsp_result <= res_c;
`ifdef MOD_ARB_QUOTIENT_EN
        o_rsp_quotient <= quo_c;
`endif
      end else if (i_rsp_ready) begin
        o_rsp_valid <= 1'b0;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_mod_arbiter.sv
// Directed bench for mod_arbiter: a DIVIDER=24 instance for the directed steps and a
// DIVIDER=12 instance for a strided sweep across all four requesters.
`default_nettype none

module tb_mod_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_div = '0;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_result;

  logic [3:0]  v12 = '0;
  logic [63:0] div12 = '0;
  logic [3:0]  rdy12;
  logic        rv12;
  logic [1:0]  id12;
  logic [15:0] res12;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef MOD_ARB_QUOTIENT_EN
  logic [15:0] rsp_quot;
  logic [15:0] quot12;
`endif

  mod_arbiter #(
    .NUM_REQ(4), .DIVIDER(24), .ONE_DIV_DIVIDER(34'h155555555)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_dividend(req_div),
    .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_id(rsp_id),
`ifdef MOD_ARB_QUOTIENT_EN
    .o_rsp_quotient(rsp_quot),
`endif
    .o_rsp_result(rsp_result)
  );

  mod_arbiter #(
    .NUM_REQ(4), .DIVIDER(12), .ONE_DIV_DIVIDER(34'h2AAAAAAAA)
  ) dut12 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v12), .i_req_dividend(div12),
    .o_req_ready(rdy12), .o_rsp_valid(rv12), .i_rsp_ready(1'b1),
    .o_rsp_id(id12),
`ifdef MOD_ARB_QUOTIENT_EN
    .o_rsp_quotient(quot12),
`endif
    .o_rsp_result(res12)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_div(input int n, input logic [15:0] v);
    req_div[n*16 +: 16] = v;
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [15:0] res,
                         input logic [15:0] quo);
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_id"}, {30'd0, rsp_id}, {30'd0, id});
    chk({tag, "_result"}, {16'd0, rsp_result}, {16'd0, res});
`ifdef MOD_ARB_QUOTIENT_EN
    chk({tag, "_quot"}, {16'd0, rsp_quot}, {16'd0, quo});
`else
    if (quo == 16'hFFFF) $display("note: quotient 65535 not checked");
`endif
  endtask

  localparam int KMAX = 3276;
  int          kk[4];
  int          q[$];
  int          ex;
  logic        busy;

  initial begin
    // Reset state, with a request present to show ready stays low in reset
    req_valid = 4'b0001;
    #2;
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_id", {30'd0, rsp_id}, 32'd0);
    chk("rst_result", {16'd0, rsp_result}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;

    // Lone req3 right after reset is granted immediately
    req_valid = 4'b1000;
    set_div(3, 16'd5);
    #1 chk("lone3_ready", {28'd0, req_ready}, 32'b1000);
    tick();
    req_valid = 4'b0000;
    chk("lone3_lat", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk_rsp("lone3", 2'd3, 16'd5, 16'd0);

    // Single request: 100 mod 24 = 4
    req_valid = 4'b0001;
    set_div(0, 16'd100);
    #1 chk("single_ready", {28'd0, req_ready}, 32'b0001);
    tick();
    req_valid = 4'b0000;
    tick();
    chk_rsp("single", 2'd0, 16'd4, 16'd4);

    // Boundaries back-to-back from req2
    req_valid = 4'b0100;
    set_div(2, 16'd0);
    #1 chk("bnd_ready", {28'd0, req_ready}, 32'b0100);
    tick();
    set_div(2, 16'd23);
    tick();
    chk_rsp("bnd0", 2'd2, 16'd0, 16'd0);
    set_div(2, 16'd24);
    tick();
    chk_rsp("bnd23", 2'd2, 16'd23, 16'd0);
    set_div(2, 16'd65535);
    tick();
    chk_rsp("bnd24", 2'd2, 16'd0, 16'd1);
    req_valid = 4'b0000;
    tick();
    chk_rsp("bnd65535", 2'd2, 16'd15, 16'd2730);
    tick();
    chk("bnd_idle", {31'd0, rsp_valid}, 32'd0);

    // Backpressure with req1 streaming 48, 49, 50
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    set_div(1, 16'd48);
    #1 chk("bp_ready_a", {28'd0, req_ready}, 32'b0010);
    tick();
    set_div(1, 16'd49);
    chk("bp_ready_b", {28'd0, req_ready}, 32'b0010);
    tick();
    set_div(1, 16'd50);
    for (int c = 0; c < 3; c++) begin
      chk("bp_ready_drop", {28'd0, req_ready}, 32'd0);
      chk_rsp("bp_hold", 2'd1, 16'd0, 16'd2);
      tick();
    end
    chk_rsp("bp_hold_end", 2'd1, 16'd0, 16'd2);
    rsp_ready = 1'b1;
    #1 chk("bp_release_ready", {28'd0, req_ready}, 32'b0010);
    tick();
    req_valid = 4'b0000;
    chk_rsp("bp_r1", 2'd1, 16'd1, 16'd2);
    tick();
    chk_rsp("bp_r2", 2'd1, 16'd2, 16'd2);
    tick();
    chk("bp_idle", {31'd0, rsp_valid}, 32'd0);

    // Asynchronous reset with both stages full
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    set_div(0, 16'd30);
    tick();
    tick();
    req_valid = 4'b0000;
    chk_rsp("mid_full", 2'd0, 16'd6, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_result", {16'd0, rsp_result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    tick();
    chk("mid_stale_a", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("mid_stale_b", {31'd0, rsp_valid}, 32'd0);

    // Round-robin from rr_ptr=0 with all four requesting
    for (int n = 0; n < 4; n++) set_div(n, 16'(25 + n));
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_grant", {28'd0, req_ready}, 32'd1 << (k % 4));
      tick();
      if (k > 0) chk_rsp("rr_rsp", 2'(k - 1), 16'(((k - 1) % 4) + 1), 16'd1);
      else chk("rr_first_lat", {31'd0, rsp_valid}, 32'd0);
    end
    req_valid = 4'b0000;
    tick();
    chk_rsp("rr_last", 2'd1, 16'd2, 16'd1);
    tick();
    chk("rr_idle", {31'd0, rsp_valid}, 32'd0);

    // Strided sweep on the DIVIDER=12 instance, all requesters in parallel
    for (int n = 0; n < 4; n++) kk[n] = 0;
    busy = 1'b1;
    for (int cyc = 0; cyc < 20000 && busy; cyc++) begin
      for (int n = 0; n < 4; n++) begin
        v12[n] = (kk[n] <= KMAX);
        div12[n*16 +: 16] = 16'(n * 16384 + kk[n] * 5);
      end
      #1;
      if (rv12) begin
        if (q.size() == 0) begin
          chk("ex_spurious", {31'd0, rv12}, 32'd0);
        end else begin
          ex = q.pop_front();
          chk("ex_id", {30'd0, id12}, 32'(ex >> 16));
          chk("ex_res", {16'd0, res12}, 32'((ex & 16'hFFFF) % 12));
`ifdef MOD_ARB_QUOTIENT_EN
          chk("ex_quot", {16'd0, quot12}, 32'((ex & 16'hFFFF) / 12));
`endif
        end
      end
      for (int n = 0; n < 4; n++) begin
        if (v12[n] && rdy12[n]) begin
          q.push_back((n << 16) | int'(div12[n*16 +: 16]));
          kk[n]++;
        end
      end
      tick();
      busy = (q.size() != 0) || (kk[0] <= KMAX) || (kk[1] <= KMAX) ||
             (kk[2] <= KMAX) || (kk[3] <= KMAX) || rv12;
    end
    v12 = '0;
    chk("ex_complete", {31'd0, busy}, 32'd0);
    chk("ex_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
